// File: rtl/jmat_sweep_if.sv
// Host-write, BRAM port and J-stream signals of the J-matrix sweep controller.
// The slave modport is the controller side; master is the surrounding system.
interface jmat_sweep_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned IDX_W  = 10
);
  localparam int unsigned ADDR_W = 20;

  logic              start;
  logic              abort;
  logic [STEP_W-1:0] num_steps;

  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [WIDTH-1:0]  host_wr_data;

  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [WIDTH-1:0]  dina;

  logic              en_read;
  logic [ADDR_W-1:0] count_addr;
  logic [WIDTH-1:0]  j_in;

  logic [WIDTH-1:0]  j_out;
  logic              j_valid;
  logic              j_ready;
  logic [IDX_W-1:0]  j_row;
  logic [IDX_W-1:0]  j_col;
  logic [STEP_W-1:0] j_step;
  logic              j_row_end;
  logic              j_step_end;

  logic              busy;
  logic              done;

  modport slave (
    input  start, abort, num_steps,
    input  host_wr_valid, host_wr_addr, host_wr_data,
    output host_wr_ready,
    output ena, wea, addra, dina,
    output en_read, count_addr,
    input  j_in, j_ready,
    output j_out, j_valid, j_row, j_col, j_step, j_row_end, j_step_end,
    output busy, done
  );

  modport master (
    output start, abort, num_steps,
    output host_wr_valid, host_wr_addr, host_wr_data,
    input  host_wr_ready,
    input  ena, wea, addra, dina,
    input  en_read, count_addr,
    output j_in, j_ready,
    input  j_out, j_valid, j_row, j_col, j_step, j_row_end, j_step_end,
    input  busy, done
  );
endinterface

// File: rtl/jmat_sweep_ctrl.sv
// J-matrix sweep sequencer and port arbiter for the dual-port J BRAM.
// Define JSWEEP_BACKPRESSURE_EN to add a 2-entry skid buffer honoring j_ready.
module jmat_sweep_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned N_SPIN = 800,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned IDX_W  = $clog2(N_SPIN)
) (
  input  logic       clk,
  input  logic       rst,
  jmat_sweep_if.slave bus
);

  localparam int unsigned ADDR_W = 20;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPIN - 1);

  typedef struct packed {
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic [STEP_W-1:0] step;
    logic              row_end;
    logic              step_end;
  } tag_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    tag_t             tag;
  } word_t;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  row_q, col_q;
  logic [STEP_W-1:0] step_q, steps_q;
  logic [STEP_W:0]   step_inc;
  logic              last_step, last_word;
  logic              issue, can_issue, flush, wr_fire;
  logic              infl_q;
  tag_t              tag_q, tag_d;
  word_t             stage, head;
  logic              head_valid;
  logic [1:0]        remain_d;

  assign step_inc  = {1'b0, step_q} + (STEP_W+1)'(1);
  assign last_step = step_inc >= {1'b0, steps_q};
  assign last_word = (row_q == LAST_IDX) && (col_q == LAST_IDX) && last_step;
  assign flush     = bus.abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign tag_d     = {row_q, col_q, step_q, col_q == LAST_IDX,
                      (row_q == LAST_IDX) && (col_q == LAST_IDX)};
  assign stage     = {bus.j_in, tag_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and read issue
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          issue = can_issue;
          if (can_issue && last_word) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.abort)              state_d = S_IDLE;
        else if (remain_d == 2'd0)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Linear address, row/column and step counters; wrap into the next step with no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      step_q  <= '0;
      steps_q <= '0;
    end else if ((state_q == S_IDLE) && bus.start) begin
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      step_q  <= '0;
      steps_q <= (bus.num_steps == '0) ? STEP_W'(1) : bus.num_steps;
    end else if (issue) begin
      if (col_q == LAST_IDX) begin
        col_q <= '0;
        if (row_q == LAST_IDX) begin
          row_q  <= '0;
          addr_q <= '0;
          if (!last_step) step_q <= step_q + STEP_W'(1);
        end else begin
          row_q  <= row_q + IDX_W'(1);
          addr_q <= addr_q + ADDR_W'(1);
        end
      end else begin
        col_q  <= col_q + IDX_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // Tags travel one stage to line up with the BRAM read data
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      infl_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      infl_q <= issue;
      if (issue) tag_q <= tag_d;
    end
  end

`ifdef JSWEEP_BACKPRESSURE_EN
  logic [1:0] occ_q;
  word_t      skid_q [2];
  word_t      cand0, cand1;
  logic       pop;

  // Queue order is skid[0], skid[1], then the word arriving from the BRAM
  assign head_valid = (occ_q != 2'd0) || infl_q;
  assign head       = (occ_q != 2'd0) ? skid_q[0] : stage;
  assign pop        = head_valid && bus.j_ready;
  assign remain_d   = occ_q + 2'(infl_q) - 2'(pop);
  assign can_issue  = ((occ_q + 2'(infl_q)) < 2'd2) || pop;
  assign cand0      = (occ_q == 2'd0) ? stage : skid_q[0];
  assign cand1      = (occ_q == 2'd1) ? stage : skid_q[1];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q     <= 2'd0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      occ_q <= remain_d;
      if (pop) begin
        skid_q[0] <= cand1;
      end else begin
        skid_q[0] <= cand0;
        skid_q[1] <= cand1;
      end
    end
  end
`else
  logic unused_j_ready;

  assign unused_j_ready = bus.j_ready;
  assign head_valid     = infl_q;
  assign head           = stage;
  assign can_issue      = 1'b1;
  assign remain_d       = 2'd0;
`endif

  // Host write owns port A only while idle
  assign bus.host_wr_ready = (state_q == S_IDLE);
  assign wr_fire           = bus.host_wr_valid && bus.host_wr_ready;
  assign bus.ena           = wr_fire;
  assign bus.wea           = wr_fire;
  assign bus.addra         = wr_fire ? bus.host_wr_addr : '0;
  assign bus.dina          = wr_fire ? bus.host_wr_data : '0;

  assign bus.en_read    = issue;
  assign bus.count_addr = issue ? addr_q : '0;

  assign bus.j_valid    = head_valid;
  assign bus.j_out      = head_valid ? head.data         : '0;
  assign bus.j_row      = head_valid ? head.tag.row      : '0;
  assign bus.j_col      = head_valid ? head.tag.col      : '0;
  assign bus.j_step     = head_valid ? head.tag.step     : '0;
  assign bus.j_row_end  = head_valid && head.tag.row_end;
  assign bus.j_step_end = head_valid && head.tag.step_end;

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_jmat_sweep_ctrl.sv
// Self-checking bench for jmat_sweep_ctrl with N_SPIN=4 and a behavioural BRAM.
module tb_jmat_sweep_ctrl;
  localparam int N  = 4;
  localparam int NN = N * N;
  localparam int W  = 4;
  localparam int SW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] mem     [NN];
  logic [W-1:0] ref_mem [NN];

  always #5 clk = ~clk;

  jmat_sweep_if #(.WIDTH(W), .STEP_W(SW), .IDX_W(IW)) bus ();

  jmat_sweep_ctrl #(.WIDTH(W), .N_SPIN(N), .STEP_W(SW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // BRAM stand-in: port A write, port B registered read
  always @(posedge clk) begin
    if (bus.ena && bus.wea) mem[bus.addra[3:0]] <= bus.dina;
    if (bus.en_read) bus.j_in <= mem[bus.count_addr[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word k of a sweep: address k mod N^2, step k div N^2
  task automatic check_word(input int k);
    int a;
    a = k % NN;
    check("j_out",      bus.j_out,      ref_mem[a]);
    check("j_row",      bus.j_row,      a / N);
    check("j_col",      bus.j_col,      a % N);
    check("j_step",     bus.j_step,     k / NN);
    check("j_row_end",  bus.j_row_end,  (a % N) == N - 1);
    check("j_step_end", bus.j_step_end, a == NN - 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},       bus.busy,          0);
    check({tag, "_done"},       bus.done,          0);
    check({tag, "_en_read"},    bus.en_read,       0);
    check({tag, "_count_addr"}, bus.count_addr,    0);
    check({tag, "_j_valid"},    bus.j_valid,       0);
    check({tag, "_j_out"},      bus.j_out,         0);
    check({tag, "_j_tags"},     {bus.j_row, bus.j_col, bus.j_step, bus.j_row_end, bus.j_step_end}, 0);
    check({tag, "_ena_wea"},    {bus.ena, bus.wea}, 0);
    check({tag, "_wr_ready"},   bus.host_wr_ready, 1);
  endtask

  task automatic host_write(input int a, input logic [W-1:0] d);
    @(negedge clk);
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr  = 20'(a);
    bus.host_wr_data  = d;
    #1;
    check("wr_ready", bus.host_wr_ready, 1);
    check("wr_ena",   bus.ena,   1);
    check("wr_wea",   bus.wea,   1);
    check("wr_addra", bus.addra, a);
    check("wr_dina",  bus.dina,  d);
    @(posedge clk);
    #1;
    bus.host_wr_valid = 1'b0;
    ref_mem[a] = d;
  endtask

  // Cycle-exact sweep with j_ready irrelevant; optional abort, reset, or write at start
  task automatic sweep(input int n_in, input int abort_at, input int rst_at,
                       input bit wr_start, input logic [W-1:0] wr_data);
    int steps, total;
    steps = (n_in == 0) ? 1 : n_in;
    total = steps * NN;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_steps = SW'(n_in);
    if (wr_start) begin
      bus.host_wr_valid = 1'b1;
      bus.host_wr_addr  = 20'd5;
      bus.host_wr_data  = wr_data;
    end
    #1;
    if (wr_start) begin
      check("ws_ena",   bus.ena,   1);
      check("ws_addra", bus.addra, 5);
      check("ws_dina",  bus.dina,  wr_data);
    end
    @(posedge clk);
    #1;
    bus.start         = 1'b0;
    bus.host_wr_valid = 1'b0;
    bus.num_steps     = SW'($urandom);
    if (wr_start) ref_mem[5] = wr_data;
    for (int c = 1; c <= total + 3; c++) begin
      @(negedge clk);
`ifndef JSWEEP_BACKPRESSURE_EN
      bus.j_ready = 1'($urandom_range(0, 1));
`endif
      if (c == 3) begin
        bus.host_wr_valid = 1'b1;
        bus.host_wr_addr  = 20'($urandom_range(0, NN - 1));
        bus.host_wr_data  = W'($urandom);
      end
      if (c == abort_at) bus.abort = 1'b1;
      if (c == rst_at) rst = 1'b1;
      #1;
      if (c != abort_at) begin
        check("en_read", bus.en_read, c <= total);
        if (c <= total) check("count_addr", bus.count_addr, (c - 1) % NN);
      end
      check("j_valid", bus.j_valid, (c >= 2) && (c <= total + 1));
      if ((c >= 2) && (c <= total + 1)) check_word(c - 2);
      check("done",     bus.done,          c == total + 2);
      check("busy",     bus.busy,          c <= total + 2);
      check("wr_ready", bus.host_wr_ready, c > total + 2);
      if (c == 3) check("run_wr_blocked", {bus.ena, bus.wea}, 0);
      @(posedge clk);
      #1;
      bus.host_wr_valid = 1'b0;
      if ((c == abort_at) || (c == rst_at)) begin
        bus.abort = 1'b0;
        rst       = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #1;
          check_idle((c == rst_at) ? "rst_mid" : "abort");
        end
        break;
      end
    end
  endtask

`ifdef JSWEEP_BACKPRESSURE_EN
  // Flow-controlled sweep: order, uniqueness and occupancy checked, not timing
  task automatic sweep_bp(input int n_in, input bit rnd);
    int steps, total, issued, recv, cyc;
    bit done_seen;
    steps = (n_in == 0) ? 1 : n_in;
    total = steps * NN;
    issued = 0; recv = 0; cyc = 0; done_seen = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_steps = SW'(n_in);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    while (!done_seen && (cyc < total * 4 + 20)) begin
      @(negedge clk);
      cyc++;
      bus.j_ready = rnd ? 1'($urandom_range(0, 1)) : ((cyc % 4 == 1) || (cyc % 4 == 0));
      #1;
      check("bp_outstanding", (issued - recv) <= 2, 1);
      if (bus.en_read) begin
        check("bp_count_addr", bus.count_addr, issued % NN);
        issued++;
        check("bp_overissue", issued <= total, 1);
      end
      if (bus.j_valid) begin
        check_word(recv);
        if (bus.j_ready) recv++;
      end
      if (bus.done) begin
        done_seen = 1'b1;
        check("bp_recv_total",   recv,   total);
        check("bp_issued_total", issued, total);
      end
    end
    check("bp_done_seen", done_seen, 1);
    @(negedge clk);
    #1;
    check_idle("bp_end");
    bus.j_ready = 1'b1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tot, ab;
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.num_steps     = '0;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_addr  = '0;
    bus.host_wr_data  = '0;
    bus.j_ready       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    for (int a = 0; a < NN; a++) host_write(a, W'(a));
    sweep(1, 0, 0, 1'b0, '0);
    sweep(3, 0, 0, 1'b0, '0);
    sweep(0, 0, 0, 1'b0, '0);
    sweep(1, 0, 0, 1'b1, ~ref_mem[5]);
    sweep(1, 8, 0, 1'b0, '0);
    sweep(1, 0, 0, 1'b0, '0);
    sweep(1, 0, NN + 1, 1'b0, '0);
    sweep(2, 0, 0, 1'b0, '0);

    for (int a = 0; a < NN; a++) host_write(a, W'($urandom));
    for (int i = 0; i < 4; i++) begin
      n   = $urandom_range(0, 3);
      tot = ((n == 0) ? 1 : n) * NN;
      ab  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, tot + 1) : 0;
      sweep(n, ab, 0, 1'($urandom_range(0, 1)), W'($urandom));
    end

`ifdef JSWEEP_BACKPRESSURE_EN
    sweep_bp(2, 1'b0);
    sweep_bp(2, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jmat_sweep_ctrl.md
Name: jmat_sweep_ctrl

Overview:
- Sequencer and port arbiter for the dual-port J-coupling BRAM.
  - Port A: write port, driven by host load writes.
  - Port B: read port, driven by the annealing sweep.
- On start, it streams the full N_SPIN x N_SPIN matrix row-major once per annealing step, for num_steps steps.
  - Each J word goes to the spin-update datapath tagged with row, column and step.
- Sits between the host/config interface, the J BRAM wrapper and the spin array.

Parameters:
- WIDTH, 4, J word width; matches the BRAM data width.
- N_SPIN, 800, spin count; N_SPIN*N_SPIN <= 2^20.
- STEP_W, 16, width of the step count and step index.
- IDX_W, $clog2(N_SPIN), width of the row and column tags.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins the sweep when in IDLE
- abort  in  1  stops the sweep; returns to IDLE
- num_steps  in  STEP_W  number of annealing steps; sampled at start
- host_wr_valid  in  1  host write request
- host_wr_ready  out  1  host write accepted this cycle
- host_wr_addr  in  20  host write address
- host_wr_data  in  WIDTH  host write data
- ena  out  1  BRAM port A enable
- wea  out  1  BRAM port A write enable
- addra  out  20  BRAM port A address
- dina  out  WIDTH  BRAM port A data
- en_read  out  1  BRAM port B enable
- count_addr  out  20  BRAM port B address
- j_in  in  WIDTH  BRAM port B data (doutb); valid 1 cycle after en_read
- j_out  out  WIDTH  J word to the datapath
- j_valid  out  1  j_out and its tags are valid
- j_ready  in  1  downstream accept; used only with the optional feature
- j_row  out  IDX_W  row tag of j_out
- j_col  out  IDX_W  column tag of j_out
- j_step  out  STEP_W  step tag of j_out
- j_row_end  out  1  j_col == N_SPIN-1
- j_step_end  out  1  last word of the current step
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset: state = IDLE; all outputs 0; counters cleared; output buffer flushed. A reset asserted mid-sweep takes effect at the next edge.
- Host write path:
  - host_wr_ready = (state == IDLE). Combinational; does not depend on valid.
  - When host_wr_valid && host_wr_ready: ena = wea = 1, addra = host_wr_addr, dina = host_wr_data, all combinational, same cycle.
  - Otherwise ena = wea = 0.
  - A write and start in the same cycle are both accepted. The write commits at that edge, before the first read is issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Latch steps = max(num_steps, 1). Reset the linear address, row, column and step counters to 0.
  - RUN: each issue cycle drives en_read = 1 and count_addr = linear address (row*N_SPIN + col, kept as an incrementing counter, no multiplier).
    - Column wraps at N_SPIN-1: column -> 0 and row increments.
    - At row = column = N_SPIN-1: if step+1 < steps, the address, row and column wrap to 0 and step increments, with no bubble.
    - Otherwise the last read issues and the FSM moves to DRAIN.
  - DRAIN: en_read = 0; wait until the last word has left j_out. Then -> DONE.
  - DONE: done = 1 for one cycle; -> IDLE.
  - abort in RUN or DRAIN: -> IDLE next edge. The buffer is flushed, j_valid drops, done does not pulse. abort in IDLE or DONE is ignored.
  - start outside IDLE is ignored.
- Read latency: the row/column/step/end tags are pipelined one stage to align with j_in. j_valid follows the issuing en_read by exactly 1 cycle.
- Throughput without backpressure: one word per cycle. Total words = steps*N_SPIN^2; RUN lasts exactly that many cycles.
- j_step_end is asserted on the final word of each step, including the final word overall.

Optional Feature:
- Macro: JSWEEP_BACKPRESSURE_EN.
- Defined:
  - A 2-entry skid buffer holds j_out and its tags.
  - A read issues only when (buffer occupancy + in-flight reads) < 2, or when a word is popped this cycle.
  - A word pops on j_valid && j_ready.
  - While j_ready = 0, the data, tags and j_valid hold stable and no word is lost or duplicated.
  - DRAIN exits only when the buffer is empty.
- Undefined: j_ready is ignored (port remains, unconnected internally); j_out = j_in registered-through with aligned tags; no buffer.

Test Plan:
- N_SPIN=4, steps=1: host writes 16 words with data = addr[3:0] -> count_addr 0..15 on consecutive cycles; j_out 0..15 one cycle later; j_row_end at cols 3; j_step_end and then done once; busy low after.
- N_SPIN=4, num_steps=3: 48 words with no gap; j_step 0,1,2; count_addr wraps 15 -> 0 back-to-back; done 2 cycles after the last issue.
- num_steps=0 -> behaves as 1 step, 16 words, done pulses.
- Write at addr 5 and start in the same cycle -> the first sweep reads the new value at addr 5. A host write during RUN -> host_wr_ready = 0, wea = 0.
- abort after 7 words -> IDLE next edge, j_valid = 0, no done. A subsequent start replays from addr 0. rst mid-DRAIN -> all outputs 0.
- JSWEEP_BACKPRESSURE_EN, j_ready toggling 1,0,0,1 repeating over 2 steps -> 32 words in order, each tag exactly once, at most 1 word in flight, no overrun.
